hvac_zone_ctrl: RTL
===================

// Module: hvac_zone_ctrl
// PURPOSE
// Multi-zone heating/cooling controller. Generalises the single-zone thermostat FSM to:
// - N_ZONES independent zones
// - run-time setpoint and hysteresis
// - heat/cool/auto mode select
// - minimum-on and minimum-off (compressor protection) timers
// Sits between the temperature sensor front end and the heater/cooler/fan drivers.
// PARAMETERS
// TEMP_W   5  width of each unsigned temperature, setpoint and hysteresis value
// N_ZONES  2  number of independent zone FSMs
// MIN_ON   4  minimum cycles heating/cooling stays asserted once started (>=1)
// MIN_OFF  3  lockout cycles after heating/cooling drops (0 = no lockout)
// PORTS
// clk          in   1                clock, all state on rising edge
// rst_n        in   1                reset, asynchronous, active-low
// en           in   1                global enable; 0 forces all zones off
// mode         in   2                00 off, 01 heat only, 10 cool only, 11 auto
// setpoint     in   TEMP_W           target temperature, shared by all zones
// hyst         in   TEMP_W           hysteresis band, shared by all zones
// temperature  in   N_ZONES*TEMP_W   zone z at [z*TEMP_W +: TEMP_W]
// heating      out  N_ZONES          heater drive per zone
// cooling      out  N_ZONES          cooler drive per zone
// lockout      out  N_ZONES          zone in min-off lockout
// fan          out  1                OR of all heating|cooling|lockout bits
// BEHAVIOUR
// - Reset (rst_n=0, async): every zone goes to IDLE; all outputs 0; all counters 0.
// - Outputs are registered and decoded from state:
//   - HEAT -> heating=1
//   - COOL -> cooling=1
//   - LOCK -> lockout=1
//   - fan is a registered OR, valid in the same cycle as the zone outputs.
// - Latency: inputs sampled at edge k are visible on the outputs after edge k (1 cycle).
// - Thresholds are computed in TEMP_W+1 bits and saturate:
//   - lo = max(setpoint-hyst, 0)
//   - hi = min(setpoint+hyst, 2^TEMP_W-1)
// - allow_h = en & mode[0]; allow_c = en & mode[1].
// - Per-zone FSM. IDLE:
//   - go HEAT if allow_h & t<=lo & !(allow_c & t>=hi)
//   - go COOL if allow_c & t>=hi & !(allow_h & t<=lo)
//   - both conditions true (e.g. hyst=0, t==setpoint): stay IDLE.
// - HEAT: cnt increments each cycle, saturating at MIN_ON-1.
//   - Exit when (t>=setpoint & cnt==MIN_ON-1) or !allow_h; an !allow_h exit is immediate, ignoring MIN_ON.
//   - Exit goes to LOCK if MIN_OFF>0, else IDLE; cnt cleared on exit.
// - COOL: mirror of HEAT, using t<=setpoint and allow_c.
// - LOCK: lasts exactly MIN_OFF cycles, with heating=cooling=0 throughout.
//   - Then IDLE for at least one cycle before any new activation.
//   - en/mode changes do not shorten LOCK.
// - HEAT<->COOL never directly; always via LOCK/IDLE.
// - heating & cooling is never 1 in the same zone.
// - setpoint/hyst changes take effect on the next edge; MIN_ON is still honoured.
// - Counter width is $clog2(max(MIN_ON,MIN_OFF)+1).
// - Zones are fully independent; only en/mode/setpoint/hyst and fan are shared.
// TESTING
// - Defaults, setpoint=20, hyst=2, mode=11, en=1:
//   - t0=18 -> heating[0]=1 one cycle later
//   - t0=20 at cycle 2 of HEAT -> heating stays 1 until 4 cycles total
//   - then lockout=1 for 3 cycles, then IDLE
// - Zone1 t1=22 while zone0 t0=19:
//   - cooling[1]=1, zone0 idle, fan=1
//   - t1=20 after MIN_ON -> cooling[1]=0, lockout[1]=1
// - hyst=0, t=20, mode=11 -> both conditions true, zone stays IDLE, all outputs 0.
// - Saturation:
//   - setpoint=1, hyst=5 -> lo=0: heat only at t=0
//   - setpoint=30, hyst=5 -> hi=31: cool only at t=31
// - Mode/enable forcing:
//   - in HEAT, mode->10 -> heating=0 next cycle (before MIN_ON), then 3 LOCK cycles
//   - in COOL, en=0 -> cooling=0 next cycle, then 3 LOCK cycles
// - rst_n low mid-HEAT, between clock edges -> outputs 0 immediately
//   - after release with t=18, HEAT re-enters with a fresh MIN_ON count.

Source files
------------

// File: rtl/hvac_zone_ctrl.sv
// rtl/hvac_zone_ctrl.sv - multi-zone heat/cool controller with min-on/min-off protection
// One IDLE/HEAT/COOL/LOCK machine per zone; setpoint, hysteresis, mode and enable are shared.
module hvac_zone_ctrl #(
  parameter int TEMP_W  = 5,
  parameter int N_ZONES = 2,
  parameter int MIN_ON  = 4,
  parameter int MIN_OFF = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [TEMP_W-1:0]         setpoint,
  input  logic [TEMP_W-1:0]         hyst,
  input  logic [N_ZONES*TEMP_W-1:0] temperature,
  output logic [N_ZONES-1:0]        heating,
  output logic [N_ZONES-1:0]        cooling,
  output logic [N_ZONES-1:0]        lockout,
  output logic                      fan
);

  localparam int CNT_MAX = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(MIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'((MIN_OFF > 0) ? MIN_OFF - 1 : 0);

  typedef enum logic [1:0] {IDLE, HEAT, COOL, LOCK} state_e;
  localparam state_e EXIT_ST = (MIN_OFF > 0) ? LOCK : IDLE;

  state_e             state_q [N_ZONES];
  state_e             state_d [N_ZONES];
  logic [CNT_W-1:0]   cnt_q   [N_ZONES];
  logic [CNT_W-1:0]   cnt_d   [N_ZONES];
  logic [N_ZONES-1:0] heating_q, cooling_q, lockout_q;
  logic [N_ZONES-1:0] heating_d, cooling_d, lockout_d;
  logic               fan_q;

  logic [TEMP_W:0]    sum_w;
  logic [TEMP_W-1:0]  lo_w, hi_w, t_w;
  logic               allow_h, allow_c, heat_ok, cool_ok;

  // Thresholds saturate at 0 and full scale instead of wrapping.
  always_comb begin
    sum_w   = {1'b0, setpoint} + {1'b0, hyst};
    hi_w    = sum_w[TEMP_W] ? '1 : sum_w[TEMP_W-1:0];
    lo_w    = (setpoint >= hyst) ? (setpoint - hyst) : '0;
    allow_h = en & mode[0];
    allow_c = en & mode[1];
  end

  always_comb begin
    t_w       = '0;
    heat_ok   = 1'b0;
    cool_ok   = 1'b0;
    heating_d = '0;
    cooling_d = '0;
    lockout_d = '0;
    for (int z = 0; z < N_ZONES; z++) begin
      state_d[z] = state_q[z];
      cnt_d[z]   = cnt_q[z];
      t_w        = temperature[z*TEMP_W +: TEMP_W];
      heat_ok    = allow_h & (t_w <= lo_w);
      cool_ok    = allow_c & (t_w >= hi_w);
      case (state_q[z])
        IDLE: begin
          cnt_d[z] = '0;
          if (heat_ok && !cool_ok)      state_d[z] = HEAT;
          else if (cool_ok && !heat_ok) state_d[z] = COOL;
        end
        HEAT: begin
          if (!allow_h || (t_w >= setpoint && cnt_q[z] == ON_LAST)) begin
            state_d[z] = EXIT_ST;
            cnt_d[z]   = '0;
          end else if (cnt_q[z] != ON_LAST) begin
            cnt_d[z] = cnt_q[z] + CNT_W'(1);
          end
        end
        COOL: begin
          if (!allow_c || (t_w <= setpoint && cnt_q[z] == ON_LAST)) begin
            state_d[z] = EXIT_ST;
            cnt_d[z]   = '0;
          end else if (cnt_q[z] != ON_LAST) begin
            cnt_d[z] = cnt_q[z] + CNT_W'(1);
          end
        end
        default: begin
          // Lockout runs to completion regardless of en/mode.
          if (cnt_q[z] == OFF_LAST) begin
            state_d[z] = IDLE;
            cnt_d[z]   = '0;
          end else begin
            cnt_d[z] = cnt_q[z] + CNT_W'(1);
          end
        end
      endcase
      heating_d[z] = (state_d[z] == HEAT);
      cooling_d[z] = (state_d[z] == COOL);
      lockout_d[z] = (state_d[z] == LOCK);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int z = 0; z < N_ZONES; z++) begin
        state_q[z] <= IDLE;
        cnt_q[z]   <= '0;
      end
      heating_q <= '0;
      cooling_q <= '0;
      lockout_q <= '0;
      fan_q     <= 1'b0;
    end else begin
      for (int z = 0; z < N_ZONES; z++) begin
        state_q[z] <= state_d[z];
        cnt_q[z]   <= cnt_d[z];
      end
      heating_q <= heating_d;
      cooling_q <= cooling_d;
      lockout_q <= lockout_d;
      fan_q     <= |{heating_d, cooling_d, lockout_d};
    end
  end

  assign heating = heating_q;
  assign cooling = cooling_q;
  assign lockout = lockout_q;
  assign fan     = fan_q;

endmodule
